// File: rtl/press_scheduler.sv
// press_scheduler: round-robin arbiter turning button press pulses into handshaked commands with a post-grant lockout.
module press_scheduler #(
  parameter int NBTN = 4,
  parameter int LOCK_CYC = 12500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] press,
  input  logic            cmd_ready,
  input  logic            clr_ovr,
  output logic            cmd_valid,
  output logic [1:0]      cmd_id,
  output logic [NBTN-1:0] pending,
  output logic [NBTN-1:0] overrun,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, OFFER, LOCK} state_t;
  state_t      state;
  logic [1:0]  ptr, sel;
  logic [30:0] cnt;
  logic [3:0]  rot, gnt;
  // rotate pending so the search always starts at bit 0, then map back by adding ptr
  always_comb begin
    rot = 4'({pending, pending} >> ptr);
    sel = ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
    gnt = (state == IDLE && |pending) ? 4'(4'b1 << sel) : 4'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      overrun   <= '0;
      cmd_valid <= 1'b0;
      cmd_id    <= 2'd0;
      ptr       <= 2'd0;
      cnt       <= '0;
    end else begin
      pending <= (pending & ~gnt) | press;
      overrun <= (clr_ovr ? 4'b0 : overrun) | (press & pending & ~gnt);
      case (state)
        IDLE: if (|pending) begin
          cmd_valid <= 1'b1;
          cmd_id    <= sel;
          state     <= OFFER;
        end
        OFFER: if (cmd_ready) begin
          cmd_valid <= 1'b0;
          ptr       <= cmd_id + 2'd1;
          cnt       <= '0;
          state     <= LOCK;
        end
        LOCK: if (cnt == 31'(LOCK_CYC - 1)) begin
          cnt   <= '0;
          state <= IDLE;
        end else cnt <= cnt + 31'd1;
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_press_scheduler.sv
// tb_press_scheduler: random and directed stimulus against a queue-based reference model with a negedge monitor.
module tb_press_scheduler;
  localparam int LOCK = 4;
  logic clk = 0, rst, cmd_ready, clr_ovr, cmd_valid, busy;
  logic [3:0] press, pending, overrun;
  logic [1:0] cmd_id;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] m_pend, m_ovr;
  int m_ptr, m_lock, m_id;
  bit m_offer;
  int q[$];

  press_scheduler #(.NBTN(4), .LOCK_CYC(LOCK)) dut (
    .clk(clk), .rst(rst), .press(press), .cmd_ready(cmd_ready), .clr_ovr(clr_ovr),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .pending(pending), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_pend = 0; m_ovr = 0; m_ptr = 0; m_lock = 0; m_offer = 0; m_id = 0;
    q.delete();
  endtask

  // reference: offers only from idle, lockout counted down as remaining cycles
  task automatic step();
    logic [3:0] g;
    bit found;
    g = 0;
    found = 0;
    if (!m_offer && m_lock == 0) begin
      if (m_pend != 0) begin
        for (int k = 0; k < 4; k++) begin
          int j;
          j = (m_ptr + k) % 4;
          if (!found && m_pend[j]) begin
            m_id = j;
            found = 1;
          end
        end
        g[m_id] = 1'b1;
        m_offer = 1;
        q.push_back(m_id);
      end
    end else if (m_offer) begin
      if (cmd_ready) begin
        m_offer = 0;
        m_lock = LOCK;
        m_ptr = (m_id + 1) % 4;
      end
    end else m_lock--;
    m_ovr = (clr_ovr ? 4'b0 : m_ovr) | (press & m_pend & ~g);
    m_pend = (m_pend & ~g) | press;
  endtask

  task automatic cyc(input logic [3:0] p, input logic r, input logic c);
    press = p; cmd_ready = r; clr_ovr = c;
    @(posedge clk);
    step();
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmd_valid", 32'(cmd_valid), 32'(m_offer));
      chk("busy", 32'(busy), 32'(m_offer || m_lock > 0));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (cmd_valid && m_offer) chk("cmd_id_hold", 32'(cmd_id), 32'(m_id));
      if (cmd_valid && cmd_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL accept: got handshake on id %0d expected no offer at %0t", cmd_id, $time);
        end else chk("cmd_id", 32'(cmd_id), 32'(q.pop_front()));
      end
    end
  end

  initial begin
    logic [3:0] p;
    rst = 1; press = 0; cmd_ready = 0; clr_ovr = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_id", 32'(cmd_id), 0);
    rst = 0;
    cyc(4'b0001, 1, 0);
    chk("lat_pending", 32'(pending), 32'h1);
    cyc(4'b0000, 1, 0);
    chk("lat_valid", 32'(cmd_valid), 1);
    repeat (8) cyc(4'b0000, 1, 0);
    cyc(4'b1111, 1, 0);
    repeat (26) cyc(4'b0000, 1, 0);
    chk("rr_overrun", 32'(overrun), 0);
    cyc(4'b0001, 0, 0);
    repeat (3) cyc(4'b0000, 0, 0);
    cyc(4'b1000, 0, 0);
    repeat (8) cyc(4'b0000, 0, 0);
    chk("bp_pending", 32'(pending), 32'h8);
    repeat (14) cyc(4'b0000, 1, 0);
    cyc(4'b0001, 0, 0);
    cyc(4'b0000, 0, 0);
    cyc(4'b0100, 0, 0);
    cyc(4'b0100, 0, 0);
    chk("ovr_set", 32'(overrun), 32'h4);
    cyc(4'b0000, 0, 1);
    chk("ovr_clr", 32'(overrun), 0);
    repeat (20) cyc(4'b0000, 1, 0);
    cyc(4'b0010, 1, 0);
    cyc(4'b0010, 1, 0);
    chk("coll_pending", 32'(pending), 32'h2);
    chk("coll_overrun", 32'(overrun), 0);
    repeat (14) cyc(4'b0000, 1, 0);
    cyc(4'b0001, 1, 0);
    cyc(4'b0000, 1, 0);
    cyc(4'b0000, 1, 0);
    cyc(4'b1010, 1, 0);
    cyc(4'b0000, 1, 0);
    #3 rst = 1;
    #1;
    chk("arst_valid", 32'(cmd_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pending", 32'(pending), 0);
    mreset();
    @(posedge clk);
    #1 rst = 0;
    repeat (10) cyc(4'b0000, 1, 0);
    repeat (600) begin
      for (int i = 0; i < 4; i++) p[i] = ($urandom_range(0, 7) == 0);
      cyc(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    repeat (40) cyc(4'b0000, 1, 0);
    chk("queue_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
